// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared op encodings, FSM state enum and PC width for the PC sequencer
package pc_seq_pkg;
   localparam int PC_W = 8;
   localparam logic [2:0] OP_NEXT   = 3'd0;
   localparam logic [2:0] OP_JUMP   = 3'd1;
   localparam logic [2:0] OP_BRANCH = 3'd2;
   localparam logic [2:0] OP_CALL   = 3'd3;
   localparam logic [2:0] OP_RET    = 3'd4;
   localparam logic [2:0] OP_HALT   = 3'd5;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT, S_FAULT} state_e;
endpackage

// File: rtl/pc_sequencer_stack.sv
// pc_ret_stack: LIFO return-address stack; entry contents are not reset, only the depth
module pc_ret_stack #(
   parameter int DEPTH = 4,
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic         full,
   output logic         empty,
   output logic [3:0]   depth,
   output logic [W-1:0] top
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wi, ti;
   assign wi = depth[AW-1:0];
   assign ti = AW'(depth - 4'd1);
   assign full = depth == 4'(DEPTH);
   assign empty = depth == 4'd0;
   assign top = mem[ti];
   // depth counter; push wins over pop, overflow/underflow requests are ignored
   always_ff @(posedge clk) begin
      if (!reset) depth <= 4'd0;
      else if (push && !full) depth <= depth + 4'd1;
      else if (pop && !empty) depth <= depth - 4'd1;
   end
   // entry storage written on a successful push
   always_ff @(posedge clk) begin
      if (reset && push && !full) mem[wi] <= din;
   end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: IDLE/RUN/HALT/FAULT fetch-address sequencer; return stack enabled by PC_SEQ_STACK_EN
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_VECTOR = 8'h00,
   parameter int STACK_DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            resume,
   input  logic            stall,
   input  logic            op_valid,
   input  logic [2:0]      op,
   input  logic [PC_W-1:0] target,
   input  logic            cond,
   output logic [PC_W-1:0] PC,
   output logic            pc_valid,
   output logic            halted,
   output logic            fault,
   output logic [3:0]      sp_depth
);
   state_e state, state_n;
   logic [PC_W-1:0] pc_n, pc1;
   logic [2:0] eop;
   logic act;
   assign eop = op_valid ? op : OP_NEXT;
   assign act = state == S_RUN && !stall;
   assign pc1 = PC + 1'b1;
   assign pc_valid = act;
   assign halted = state == S_HALT;
   assign fault = state == S_FAULT;
`ifdef PC_SEQ_STACK_EN
   logic full, empty;
   logic [PC_W-1:0] top;
   pc_ret_stack #(.DEPTH(STACK_DEPTH), .W(PC_W)) u_stack (
      .clk(clk),
      .reset(reset),
      .push(act && eop == OP_CALL),
      .pop(act && eop == OP_RET),
      .din(pc1),
      .full(full),
      .empty(empty),
      .depth(sp_depth),
      .top(top)
   );
`else
   assign sp_depth = 4'd0;
`endif
   // state and PC registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_IDLE;
         PC <= RESET_VECTOR;
      end else begin
         state <= state_n;
         PC <= pc_n;
      end
   end
   // next state and next PC; stall freezes everything while in RUN
   always_comb begin
      state_n = state;
      pc_n = PC;
      case (state)
         S_IDLE: state_n = start ? S_RUN : S_IDLE;
         S_HALT: state_n = resume ? S_RUN : S_HALT;
         S_RUN: if (!stall) begin
            case (eop)
               OP_JUMP:   pc_n = target;
               OP_BRANCH: pc_n = cond ? pc1 + target : pc1;
`ifdef PC_SEQ_STACK_EN
               OP_CALL: begin
                  pc_n = full ? PC : target;
                  state_n = full ? S_FAULT : S_RUN;
               end
               OP_RET: begin
                  pc_n = empty ? PC : top;
                  state_n = empty ? S_FAULT : S_RUN;
               end
`else
               OP_CALL:   pc_n = target;
               OP_RET:    pc_n = pc1;
`endif
               OP_HALT:   state_n = S_HALT;
               default:   pc_n = pc1;
            endcase
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks of pc_sequencer against a behavioural model
module tb_pc_sequencer;
`ifdef PC_SEQ_STACK_EN
   localparam bit STK = 1'b1;
`else
   localparam bit STK = 1'b0;
`endif
   localparam int DEPTH = 4;
   localparam int RV = 8'h00;
   logic clk = 1'b0, reset = 1'b0, start = 1'b0, resume = 1'b0, stall = 1'b0, op_valid = 1'b0, cond = 1'b0;
   logic [2:0] op = 3'd0;
   logic [7:0] target = 8'h00;
   logic [7:0] PC;
   logic pc_valid, halted, fault;
   logic [3:0] sp_depth;
   int n_vec = 0, n_err = 0;
   int m_pc;
   string m_mode;
   int stk[$];
   pc_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .resume(resume), .stall(stall),
      .op_valid(op_valid), .op(op), .target(target), .cond(cond),
      .PC(PC), .pc_valid(pc_valid), .halted(halted), .fault(fault), .sp_depth(sp_depth)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask
   // apply one cycle of inputs, advance the model, then compare every output
   task automatic cyc(input bit rs, input bit st, input bit rm, input bit sl,
                      input bit ov, input bit [2:0] o, input bit [7:0] t, input bit c);
      int eo;
      reset = rs; start = st; resume = rm; stall = sl; op_valid = ov; op = o; target = t; cond = c;
      eo = ov ? int'(o) : 0;
      if (!rs) begin
         m_pc = RV; m_mode = "IDLE"; stk.delete();
      end else if (m_mode == "IDLE") begin
         if (st) m_mode = "RUN";
      end else if (m_mode == "HALT") begin
         if (rm) m_mode = "RUN";
      end else if (m_mode == "RUN" && !sl) begin
         if (eo == 1) m_pc = t;
         else if (eo == 2) m_pc = c ? (m_pc + 1 + int'($signed(t))) & 255 : (m_pc + 1) & 255;
         else if (eo == 3 && STK) begin
            if (stk.size() == DEPTH) m_mode = "FAULT";
            else begin stk.push_back((m_pc + 1) & 255); m_pc = t; end
         end else if (eo == 3) m_pc = t;
         else if (eo == 4 && STK) begin
            if (stk.size() == 0) m_mode = "FAULT";
            else m_pc = stk.pop_back();
         end else if (eo == 5) m_mode = "HALT";
         else m_pc = (m_pc + 1) & 255;
      end
      @(posedge clk);
      #1;
      check("PC", int'(PC), m_pc);
      check("pc_valid", int'(pc_valid), int'(m_mode == "RUN" && !sl));
      check("halted", int'(halted), int'(m_mode == "HALT"));
      check("fault", int'(fault), int'(m_mode == "FAULT"));
      check("sp_depth", int'(sp_depth), stk.size());
   endtask
   task automatic do_op(input bit [2:0] o, input bit [7:0] t, input bit c);
      cyc(1, 0, 0, 0, 1, o, t, c);
   endtask
   initial begin
      m_pc = RV; m_mode = "IDLE";
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      check("rst_pc", int'(PC), 8'h00);
      cyc(1, 1, 0, 0, 0, 0, 0, 0);
      check("start_pc", int'(PC), 8'h00);
      for (int i = 1; i <= 3; i++) begin
         do_op(0, 0, 0);
         check("seq_pc", int'(PC), i);
         check("seq_valid", int'(pc_valid), 1);
      end
      do_op(1, 8'h10, 0);
      do_op(2, 8'hF0, 1);
      check("br_taken", int'(PC), 8'h01);
      do_op(1, 8'h10, 0);
      do_op(2, 8'hF0, 0);
      check("br_not", int'(PC), 8'h11);
      do_op(1, 8'hFF, 0);
      do_op(0, 0, 0);
      check("wrap", int'(PC), 8'h00);
      cyc(1, 0, 0, 1, 1, 1, 8'h55, 0);
      check("stall", int'(PC), 8'h00);
      cyc(1, 1, 1, 0, 0, 0, 0, 0);
      do_op(1, 8'h20, 0);
      do_op(3, 8'h40, 0);
      if (STK) check("call_depth", int'(sp_depth), 1);
      check("call_pc", int'(PC), 8'h40);
      do_op(4, 0, 0);
      check("ret_pc", int'(PC), STK ? 8'h21 : 8'h41);
      for (int i = 0; i < 5; i++) do_op(3, 8'(8'h60 + i), 0);
      if (STK) begin
         check("ovf_fault", int'(fault), 1);
         check("ovf_depth", int'(sp_depth), 4);
         check("ovf_pc", int'(PC), 8'h63);
      end
      cyc(1, 1, 1, 0, 1, 1, 8'h77, 0);
      do_op(4, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      check("flt_clr", int'(fault), 0);
      cyc(1, 1, 0, 0, 0, 0, 0, 0);
      do_op(4, 0, 0);
      if (STK) check("udf_fault", int'(fault), 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0, 0);
      do_op(1, 8'h30, 0);
      do_op(5, 0, 0);
      check("halt", int'(halted), 1);
      check("halt_pc", int'(PC), 8'h30);
      cyc(1, 1, 0, 0, 1, 1, 8'h99, 0);
      cyc(1, 0, 1, 0, 0, 0, 0, 0);
      check("resume", int'(halted), 0);
      do_op(0, 0, 0);
      do_op(3, 8'h50, 0);
      cyc(0, 0, 0, 0, 1, 3, 8'h70, 0);
      check("rst_mid", int'(PC), RV);
      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(0, 63) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 4) == 0, $urandom_range(0, 5) != 0, 3'($urandom_range(0, 7)),
             8'($urandom), 1'($urandom));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 8'h00, the PC value loaded on reset.
REQ-002 SHALL have parameter STACK_DEPTH, default 4, the number of return-stack entries (legal range 2..8).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset, asserted when 0 and sampled on the clk rising edge.
REQ-005 SHALL have port start  input  1  leaves IDLE and begins fetch sequencing.
REQ-006 SHALL have port resume  input  1  leaves HALT.
REQ-007 SHALL have port stall  input  1  holds PC and stack this cycle.
REQ-008 SHALL have port op_valid  input  1  qualifies op/target/cond.
REQ-009 SHALL have port op  input  3  sequencing op: 0 NEXT, 1 JUMP, 2 BRANCH, 3 CALL, 4 RET, 5 HALT, 6-7 treated as NEXT.
REQ-010 SHALL have port target  input  8  absolute address for JUMP/CALL; signed two's-complement offset for BRANCH.
REQ-011 SHALL have port cond  input  1  BRANCH taken when 1.
REQ-012 SHALL have port PC  output  8  current fetch address.
REQ-013 SHALL have port pc_valid  output  1  high only in RUN with stall low.
REQ-014 SHALL have port halted  output  1  high in HALT.
REQ-015 SHALL have port fault  output  1  high in FAULT.
REQ-016 SHALL have port sp_depth  output  4  current number of occupied stack entries.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, HALT, FAULT: IDLE->RUN on start; RUN->HALT on a valid HALT op; HALT->RUN on resume; RUN->FAULT on stack overflow or underflow; FAULT exits only on reset.
REQ-018 SHALL update PC one cycle after the op is sampled: an op presented before edge N yields the new PC after edge N.
REQ-019 SHALL, in RUN with stall=0 and op_valid=1, set PC as follows: NEXT -> PC+1; JUMP -> target; BRANCH -> PC+1+sign-extended target if cond=1, else PC+1; CALL -> push PC+1 and set PC=target; RET -> pop into PC; HALT -> PC held.
REQ-020 SHALL, in RUN with stall=0 and op_valid=0, behave as NEXT.
REQ-021 SHALL compute all PC arithmetic modulo 256, so 8'hFF+1 = 8'h00 and 8'h02+8'hFC+1 = 8'hFF.
REQ-022 SHALL treat stall=1 as having priority over op, holding PC, stack, and state.
REQ-023 SHALL hold PC in IDLE, HALT, and FAULT and ignore op there.
REQ-024 SHALL, on CALL with sp_depth=STACK_DEPTH, enter FAULT without pushing and with PC unchanged.
REQ-025 SHALL, on RET with sp_depth=0, enter FAULT with PC unchanged.
REQ-026 SHALL, when start and stall are both high in IDLE, enter RUN with PC held at RESET_VECTOR.
REQ-027 SHALL give resume no effect outside HALT and start no effect outside IDLE.

Reset
REQ-028 SHALL, when reset=0 at a clk rising edge, set PC=RESET_VECTOR, state=IDLE, sp_depth=0, pc_valid=0, halted=0, fault=0, overriding all other inputs, including when a reset arrives mid-CALL or in FAULT.
REQ-029 SHALL leave stack entry contents undefined after reset and never read them while sp_depth=0.

Configuration
REQ-030 SHALL, with macro PC_SEQ_STACK_EN defined, implement CALL/RET and the return stack as specified.
REQ-031 SHALL, without PC_SEQ_STACK_EN, execute CALL as JUMP and RET as NEXT, build no stack storage, tie sp_depth to 0, and never raise stack faults.

Structure
REQ-032 SHALL take op encodings, the FSM state enum, and the PC width constant (8) from shared package pc_seq_pkg.
REQ-033 SHALL place the return stack in sub-module pc_ret_stack (push, pop, full, empty, depth, top), instantiated only under PC_SEQ_STACK_EN.

Verification
REQ-034 SHALL cover the case: reset=0 then start, 3 cycles NEXT -> PC sequence 00,01,02,03 and pc_valid=1.
REQ-035 SHALL cover the case: PC=10, BRANCH target=8'hF0 cond=1 -> PC=01; cond=0 -> PC=11.
REQ-036 SHALL cover the case: PC=20, CALL target=40, then RET -> PC=40, sp_depth=1, then PC=21, sp_depth=0.
REQ-037 SHALL cover the case: 4 CALLs then a 5th CALL -> fault=1, PC and sp_depth=4 held, and only reset clears the fault.
REQ-038 SHALL cover the case: PC=FF NEXT -> PC=00; stall=1 with JUMP 55 -> PC unchanged.
REQ-039 SHALL cover the case: HALT op at PC=30 -> halted=1, PC=30 held; resume -> RUN; reset=0 mid-run -> PC=RESET_VECTOR, IDLE.
